fetch_queue: RTL and testbench

- Instruction fetch queue on the consumer side of the fetch controller's `write_fifo` / `fetch_instr_pc` write stream.
- Buffers 128-bit fetch packets, each holding two instruction/PC pairs, and presents them to the dual-issue decode stage through a valid/ready handshake.
- Drives the fetch controller's `stop_fetch` back-pressure input and flushes on accepted jumps.
- Sits between the fetch controller and decode in the superscalar front end.

---
 rtl/fetch_queue_if.sv | 34 +++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: write stream from the fetch controller, back-pressure,
// flush, and the valid/ready decode-side read port with status.
//   master : fetch controller / decode side (drives write, flush, dec_ready)
//   slave  : fetch_queue (drives stop_fetch, dec_*, count, overflow)
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             write_fifo;
  logic [127:0]     fetch_instr_pc;
  logic             flush;
  logic             stop_fetch;
  logic             dec_ready;
  logic             dec_valid;
  logic [31:0]      dec_instr0;
  logic [31:0]      dec_pc0;
  logic [31:0]      dec_instr1;
  logic [31:0]      dec_pc1;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output write_fifo, fetch_instr_pc, flush, dec_ready,
    input  stop_fetch, dec_valid, dec_instr0, dec_pc0, dec_instr1, dec_pc1,
           count, overflow
  );

  modport slave (
    input  write_fifo, fetch_instr_pc, flush, dec_ready,
    output stop_fetch, dec_valid, dec_instr0, dec_pc0, dec_instr1, dec_pc1,
           count, overflow
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch controller and dual-issue decode.
// Buffers 128-bit packets (two instr/PC pairs) in a first-word-fall-through
// circular buffer, raises stop_fetch near full, flushes on accepted jumps and
// flags dropped writes with a sticky overflow bit.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_queue_if slave (write stream, flush, stop_fetch,
//              decode valid/ready + head fields, count, overflow)
module fetch_queue #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - AFULL_MARGIN);

  typedef struct packed {
    logic [31:0] instr1;
    logic [31:0] pc1;
    logic [31:0] instr0;
    logic [31:0] pc0;
  } fetch_pkt_t;

  fetch_pkt_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  fetch_pkt_t       head;

  // Handshake decode; a full queue still accepts a write when decode pops.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_CNT);
    pop   = !empty && bus.dec_ready;
    push  = bus.write_fifo && (!full || pop);
    drop  = bus.write_fifo && full && !pop;
  end

  // Pointer, occupancy and overflow state; flush outranks push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Packet storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem[wr_ptr] <= fetch_pkt_t'(bus.fetch_instr_pc);
  end

  // Head packet falls through to decode.
  assign head           = mem[rd_ptr];
  assign bus.dec_valid  = !empty;
  assign bus.dec_instr0 = head.instr0;
  assign bus.dec_pc0    = head.pc0;
  assign bus.dec_instr1 = head.instr1;
  assign bus.dec_pc1    = head.pc1;

  // Back-pressure decoded from registered occupancy only.
  assign bus.stop_fetch = (count_q >= AFULL_CNT);
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=8, AFULL_MARGIN=2).
module tb_fetch_queue;

  localparam int unsigned DEPTH        = 8;
  localparam int unsigned AFULL_MARGIN = 2;
  localparam int unsigned CW           = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   wr_i;
  int   rd_i;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] pkt(input int unsigned i);
    return {32'hA000_0000 + 32'(i), 32'h0000_1004 + 32'(8 * i),
            32'hB000_0000 + 32'(i), 32'h0000_1000 + 32'(8 * i)};
  endfunction

  function automatic logic [127:0] wpkt(input int unsigned i);
    return {32'hD000_0000 + 32'(i), 32'(8 * i + 4),
            32'hC000_0000 + 32'(i), 32'(8 * i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [127:0] p);
    bus.write_fifo     = 1'b1;
    bus.fetch_instr_pc = p;
    tick();
    bus.write_fifo     = 1'b0;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] obs, input int unsigned exp);
    n_assert++;
    assert (obs === CW'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    bus.write_fifo     = 1'b0;
    bus.fetch_instr_pc = '0;
    bus.flush          = 1'b0;
    bus.dec_ready      = 1'b0;
    rst                = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk_bit("rst_valid", bus.dec_valid, 1'b0);
    chk_bit("rst_stop", bus.stop_fetch, 1'b0);
    chk_bit("rst_ovf", bus.overflow, 1'b0);
    chk_cnt("rst_count", bus.count, 0);
    rst = 1'b0;

    // Single write, visible the cycle after the edge
    push_pkt(128'h00000013_00000004_00500093_00000000);
    chk_bit("w1_valid", bus.dec_valid, 1'b1);
    chk_w32("w1_pc0", bus.dec_pc0, 32'h0000_0000);
    chk_w32("w1_instr0", bus.dec_instr0, 32'h0050_0093);
    chk_w32("w1_pc1", bus.dec_pc1, 32'h0000_0004);
    chk_w32("w1_instr1", bus.dec_instr1, 32'h0000_0013);
    chk_cnt("w1_count", bus.count, 1);

    // Fill to full; stop_fetch asserts from count 6
    for (int i = 1; i < 8; i++) begin
      push_pkt(pkt(i));
      chk_cnt("fill_count", bus.count, i + 1);
      chk_bit("fill_stop", bus.stop_fetch, (i + 1) >= 6);
    end
    chk_bit("fill_ovf_clear", bus.overflow, 1'b0);
    push_pkt(pkt(8));
    chk_cnt("ovf_count", bus.count, 8);
    chk_bit("ovf_set", bus.overflow, 1'b1);
    chk_w32("ovf_head_pc0", bus.dec_pc0, 32'h0000_0000);
    chk_w32("ovf_head_instr0", bus.dec_instr0, 32'h0050_0093);

    // Async reset without a clock edge, then dec_ready on empty queue
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk_cnt("rst2_count", bus.count, 0);
    chk_bit("rst2_ovf", bus.overflow, 1'b0);
    bus.dec_ready = 1'b1;
    tick();
    bus.dec_ready = 1'b0;
    chk_cnt("empty_pop_count", bus.count, 0);
    chk_bit("empty_pop_valid", bus.dec_valid, 1'b0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_pkt(pkt(i));
    chk_cnt("full_count", bus.count, 8);
    chk_bit("full_stop", bus.stop_fetch, 1'b1);
    bus.write_fifo     = 1'b1;
    bus.fetch_instr_pc = pkt(8);
    bus.dec_ready      = 1'b1;
    chk_w32("pp_head_pc0", bus.dec_pc0, 32'h0000_1000);
    tick();
    bus.write_fifo = 1'b0;
    chk_cnt("pp_count", bus.count, 8);
    chk_bit("pp_ovf", bus.overflow, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      chk_bit("drain_valid", bus.dec_valid, 1'b1);
      chk_w32("drain_pc0", bus.dec_pc0, 32'h0000_1000 + 32'(8 * k));
      chk_w32("drain_instr1", bus.dec_instr1, 32'hA000_0000 + 32'(k));
      tick();
    end
    bus.dec_ready = 1'b0;
    chk_cnt("drain_count", bus.count, 0);
    chk_bit("drain_valid_end", bus.dec_valid, 1'b0);

    // Wrap-around: 20 packets, occupancy held at 3
    wr_i = 0;
    rd_i = 0;
    for (int cyc = 0; cyc < 60 && rd_i < 20; cyc++) begin
      bus.write_fifo     = (wr_i < 20);
      bus.fetch_instr_pc = wpkt(wr_i);
      bus.dec_ready      = (wr_i >= 3);
      chk_bit("wrap_le5", bus.count <= CW'(5), 1'b1);
      if (bus.dec_ready) begin
        chk_bit("wrap_valid", bus.dec_valid, 1'b1);
        chk_w32("wrap_pc0", bus.dec_pc0, 32'(8 * rd_i));
        rd_i++;
      end
      if (wr_i < 20) wr_i++;
      tick();
    end
    bus.write_fifo = 1'b0;
    bus.dec_ready  = 1'b0;
    chk_cnt("wrap_popped", CW'(rd_i), 20);
    chk_cnt("wrap_count_end", bus.count, 0);

    // Flush with concurrent write and pop; overflow must survive
    for (int i = 0; i < 9; i++) push_pkt(pkt(20 + i));
    chk_bit("fl_ovf_pre", bus.overflow, 1'b1);
    bus.dec_ready = 1'b1;
    repeat (4) tick();
    bus.dec_ready = 1'b0;
    chk_cnt("fl_count_pre", bus.count, 4);
    bus.flush          = 1'b1;
    bus.write_fifo     = 1'b1;
    bus.fetch_instr_pc = pkt(99);
    bus.dec_ready      = 1'b1;
    tick();
    bus.flush      = 1'b0;
    bus.write_fifo = 1'b0;
    bus.dec_ready  = 1'b0;
    chk_cnt("fl_count", bus.count, 0);
    chk_bit("fl_valid", bus.dec_valid, 1'b0);
    chk_bit("fl_stop", bus.stop_fetch, 1'b0);
    chk_bit("fl_ovf", bus.overflow, 1'b1);
    push_pkt(pkt(50));
    chk_bit("fl_post_valid", bus.dec_valid, 1'b1);
    chk_w32("fl_post_pc0", bus.dec_pc0, 32'h0000_1190);
    chk_cnt("fl_post_count", bus.count, 1);

    // Async reset mid-stream, between edges
    push_pkt(pkt(51));
    push_pkt(pkt(52));
    chk_cnt("ar_count_pre", bus.count, 3);
    #3;
    rst = 1'b1;
    #1;
    chk_cnt("ar_count", bus.count, 0);
    chk_bit("ar_valid", bus.dec_valid, 1'b0);
    chk_bit("ar_ovf", bus.overflow, 1'b0);
    rst = 1'b0;
    push_pkt(pkt(60));
    chk_cnt("ar_resume_count", bus.count, 1);
    chk_w32("ar_resume_pc0", bus.dec_pc0, 32'h0000_11E0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
